// File: rtl/i281_seq_defs.sv
// i281_seq_defs: shared state encodings for the i281 run/step/breakpoint sequencer
package i281_seq_defs;
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_HALT = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_STEP = 2'd2;
  localparam logic [STATE_W-1:0] ST_BRK  = 2'd3;
endpackage

// File: rtl/i281_exec_sequencer_if.sv
// i281_exec_sequencer_if: control/status bundle between board controls and the sequencer
interface i281_exec_sequencer_if #(parameter int PC_W = 6, parameter int CNT_W = 16);
  logic             run_req;
  logic             step_req;
  logic             halt_req;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  current_pc;
  logic             multicycle_flag;
  logic             clr_cnt;
  logic             cpu_run;
  logic             instr_done;
  logic [1:0]       state;
  logic             halted;
  logic             bp_flag;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  modport master (
    output run_req, step_req, halt_req, bp_en, bp_addr, current_pc, multicycle_flag, clr_cnt,
    input  cpu_run, instr_done, state, halted, bp_flag, cycle_count, instr_count
  );
  modport slave (
    input  run_req, step_req, halt_req, bp_en, bp_addr, current_pc, multicycle_flag, clr_cnt,
    output cpu_run, instr_done, state, halted, bp_flag, cycle_count, instr_count
  );
endinterface

// File: rtl/i281_sat_counter.sv
// i281_sat_counter: counter that sticks at all-ones; clear wins over increment
module i281_sat_counter #(parameter int W = 16) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d;
  assign q_d = clr ? '0 : (inc & ~&q) ? q + 1'b1 : q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) q <= '0;
    else q <= q_d;
endmodule

// File: rtl/i281_exec_sequencer.sv
// i281_exec_sequencer: run/step/halt/breakpoint control producing the CPU-wide run enable
module i281_exec_sequencer
  import i281_seq_defs::*;
#(
  parameter int PC_W   = 6,
  parameter int MC_LEN = 2,
  parameter int CNT_W  = 16
) (
  input logic clock,
  input logic reset,
  i281_exec_sequencer_if.slave bus
);
  localparam int MCW = $clog2(MC_LEN);
  localparam logic [MCW-1:0] MC_LAST = MCW'(MC_LEN - 1);
  logic [STATE_W-1:0] state_q, state_d;
  logic [MCW-1:0] mc_cnt_q, mc_cnt_d;
  logic step_q, bp_skip_q, bp_skip_d;
  logic step_pulse, bp_hit, cpu_run, instr_done, go_run, halted, skip_set;
  assign step_pulse = bus.step_req & ~step_q;
  assign bp_hit     = bus.bp_en & (mc_cnt_q == '0) & (bus.current_pc == bus.bp_addr) & ~bp_skip_q;
  assign cpu_run    = (state_q == ST_RUN & ~bp_hit) | (state_q == ST_STEP);
  assign instr_done = cpu_run & (~bus.multicycle_flag | mc_cnt_q == MC_LAST);
  assign go_run     = bus.run_req & ~bus.halt_req;
  assign halted     = state_q == ST_HALT | state_q == ST_BRK;
  always_comb begin
    case (state_q)
      ST_HALT: state_d = step_pulse ? ST_STEP : go_run ? ST_RUN : ST_HALT;
      ST_RUN:  state_d = bp_hit ? ST_BRK : (instr_done & ~go_run) ? ST_HALT : ST_RUN;
      ST_STEP: state_d = instr_done ? ST_HALT : ST_STEP;
      default: state_d = step_pulse ? ST_STEP : bus.run_req ? ST_BRK : ST_HALT;
    endcase
  end
  // Any resume from a stopped state lets the current PC through one breakpoint check
  assign skip_set  = halted & (state_d == ST_STEP | state_d == ST_RUN);
  assign bp_skip_d = skip_set ? 1'b1 : instr_done ? 1'b0 : bp_skip_q;
  assign mc_cnt_d  = (instr_done | ~bus.multicycle_flag) ? '0 : cpu_run ? mc_cnt_q + 1'b1 : mc_cnt_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HALT;
      mc_cnt_q  <= '0;
      step_q    <= 1'b0;
      bp_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mc_cnt_q  <= mc_cnt_d;
      step_q    <= bus.step_req;
      bp_skip_q <= bp_skip_d;
    end
  end
  assign bus.cpu_run    = cpu_run;
  assign bus.instr_done = instr_done;
  assign bus.state      = state_q;
  assign bus.halted     = halted;
  assign bus.bp_flag    = state_q == ST_BRK;
  i281_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock(clock), .reset(reset), .inc(cpu_run), .clr(bus.clr_cnt), .q(bus.cycle_count)
  );
  i281_sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clock(clock), .reset(reset), .inc(instr_done), .clr(bus.clr_cnt), .q(bus.instr_count)
  );
endmodule

// File: tb/tb_i281_exec_sequencer.sv
// tb_i281_exec_sequencer: directed scenarios plus randomized run against a behavioural model
module tb_i281_exec_sequencer;
  import i281_seq_defs::*;
  localparam int PC_W = 6, MC_LEN = 2;
  logic clock = 0, reset = 0;
  logic run_req = 0, step_req = 0, halt_req = 0, bp_en = 0, mc = 0, clr_cnt = 0;
  logic [PC_W-1:0] bp_addr = '0, pc = '0;
  int total = 0, bad = 0;
  logic obs_run, obs_done;
  int m_mode, m_sub, m_cyc, m_ins, m_cyc4, m_ins4;
  bit m_skip, m_prev, m_run, m_done, m_hit;

  i281_exec_sequencer_if #(.PC_W(PC_W), .CNT_W(16)) a ();
  i281_exec_sequencer_if #(.PC_W(PC_W), .CNT_W(4))  b ();
  assign a.run_req = run_req;   assign b.run_req = run_req;
  assign a.step_req = step_req; assign b.step_req = step_req;
  assign a.halt_req = halt_req; assign b.halt_req = halt_req;
  assign a.bp_en = bp_en;       assign b.bp_en = bp_en;
  assign a.bp_addr = bp_addr;   assign b.bp_addr = bp_addr;
  assign a.current_pc = pc;     assign b.current_pc = pc;
  assign a.multicycle_flag = mc; assign b.multicycle_flag = mc;
  assign a.clr_cnt = clr_cnt;   assign b.clr_cnt = clr_cnt;

  i281_exec_sequencer #(.PC_W(PC_W), .MC_LEN(MC_LEN), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(a.slave));
  i281_exec_sequencer #(.PC_W(PC_W), .MC_LEN(MC_LEN), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .bus(b.slave));

  always #5 clock = ~clock;

  // Model modes use the numeric state values: 0 halted, 1 running, 2 stepping, 3 at breakpoint
  task automatic model_reset();
    m_mode = 0; m_sub = 0; m_cyc = 0; m_ins = 0; m_cyc4 = 0; m_ins4 = 0;
    m_skip = 0; m_prev = 0;
  endtask

  task automatic model_comb();
    m_hit  = bp_en && m_sub == 0 && pc == bp_addr && !m_skip;
    m_run  = (m_mode == 1 && !m_hit) || m_mode == 2;
    m_done = m_run && (!mc || m_sub == MC_LEN - 1);
  endtask

  task automatic model_seq();
    bit pulse;
    pulse = step_req && !m_prev;
    if (m_done) m_skip = 0;
    case (m_mode)
      0: if (pulse) begin m_mode = 2; m_skip = 1; end
         else if (run_req && !halt_req) begin m_mode = 1; m_skip = 1; end
      1: if (m_hit) m_mode = 3;
         else if (m_done && (halt_req || !run_req)) m_mode = 0;
      2: if (m_done) m_mode = 0;
      default: if (pulse) begin m_mode = 2; m_skip = 1; end
               else if (!run_req) m_mode = 0;
    endcase
    m_sub  = (!mc || m_done) ? 0 : m_sub + int'(m_run);
    m_cyc  = clr_cnt ? 0 : (m_cyc + int'(m_run) > 65535 ? 65535 : m_cyc + int'(m_run));
    m_ins  = clr_cnt ? 0 : (m_ins + int'(m_done) > 65535 ? 65535 : m_ins + int'(m_done));
    m_cyc4 = clr_cnt ? 0 : (m_cyc4 + int'(m_run) > 15 ? 15 : m_cyc4 + int'(m_run));
    m_ins4 = clr_cnt ? 0 : (m_ins4 + int'(m_done) > 15 ? 15 : m_ins4 + int'(m_done));
    m_prev = step_req;
  endtask

  // One clock: capture combinational outputs mid-cycle, advance model on the edge
  task automatic tick();
    @(negedge clock);
    obs_run = a.cpu_run; obs_done = a.instr_done;
    model_comb();
    @(posedge clock);
    model_seq();
    #1;
  endtask

  task automatic test_reset();
    reset = 0; model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (a.state !== ST_HALT) begin bad++; $display("FAIL reset_state got=%0d exp=0", a.state); end
      total++; if (obs_run !== 1'b0) begin bad++; $display("FAIL reset_cpu_run got=%b exp=0", obs_run); end
      total++; if (a.halted !== 1'b1 || a.bp_flag !== 1'b0) begin bad++; $display("FAIL reset_flags halted=%b bp=%b exp=1/0", a.halted, a.bp_flag); end
      total++; if (a.cycle_count !== 16'd0 || a.instr_count !== 16'd0) begin bad++; $display("FAIL reset_counts cyc=%0d ins=%0d exp=0/0", a.cycle_count, a.instr_count); end
    end
  endtask

  task automatic test_step_single();
    int runs = 0, dones = 0;
    mc = 0; step_req = 1;
    for (int i = 0; i < 5; i++) begin
      tick(); runs += int'(obs_run); dones += int'(obs_done);
      total++; if (obs_run !== m_run) begin bad++; $display("FAIL step1_run cyc=%0d got=%b exp=%b", i, obs_run, m_run); end
    end
    step_req = 0; tick();
    total++; if (runs != 1 || dones != 1) begin bad++; $display("FAIL step1_pulses runs=%0d dones=%0d exp=1/1", runs, dones); end
    total++; if (a.instr_count !== 16'd1 || a.cycle_count !== 16'd1) begin bad++; $display("FAIL step1_counts ins=%0d cyc=%0d exp=1/1", a.instr_count, a.cycle_count); end
    total++; if (a.state !== ST_HALT) begin bad++; $display("FAIL step1_state got=%0d exp=0", a.state); end
  endtask

  task automatic test_step_multi();
    logic [3:0] runs, dones;
    clr_cnt = 1; tick(); clr_cnt = 0;
    mc = 1; step_req = 1;
    for (int i = 0; i < 4; i++) begin tick(); runs[i] = obs_run; dones[i] = obs_done; end
    step_req = 0; mc = 0;
    total++; if (runs !== 4'b0110) begin bad++; $display("FAIL stepmc_run got=%b exp=0110", runs); end
    total++; if (dones !== 4'b0100) begin bad++; $display("FAIL stepmc_done got=%b exp=0100", dones); end
    total++; if (a.cycle_count !== 16'd2 || a.instr_count !== 16'd1) begin bad++; $display("FAIL stepmc_counts cyc=%0d ins=%0d exp=2/1", a.cycle_count, a.instr_count); end
    total++; if (a.state !== ST_HALT) begin bad++; $display("FAIL stepmc_state got=%0d exp=0", a.state); end
  endtask

  task automatic test_breakpoint();
    int n = 0;
    bit brk = 0;
    pc = 0; bp_addr = 5; bp_en = 1; mc = 0; run_req = 1;
    for (int i = 0; i < 40 && !brk; i++) begin
      tick(); if (obs_done) begin n++; pc = pc + 1'b1; end
      brk = a.state == ST_BRK;
    end
    total++; if (!brk || n != 5 || pc != 5) begin bad++; $display("FAIL bp_first brk=%b n=%0d pc=%0d exp=1/5/5", brk, n, pc); end
    tick();
    total++; if (obs_run !== 1'b0 || a.state !== ST_BRK || a.bp_flag !== 1'b1) begin bad++; $display("FAIL bp_hold run=%b st=%0d exp=0/3", obs_run, a.state); end
    run_req = 0; tick();
    total++; if (a.state !== ST_HALT) begin bad++; $display("FAIL bp_release st=%0d exp=0", a.state); end
    run_req = 1; n = 0; brk = 0;
    for (int i = 0; i < 40 && !brk; i++) begin
      tick(); if (obs_done) begin n++; pc = (pc == 7) ? '0 : pc + 1'b1; end
      brk = a.state == ST_BRK;
    end
    total++; if (!brk || n != 8 || pc != 5) begin bad++; $display("FAIL bp_resume brk=%b n=%0d pc=%0d exp=1/8/5", brk, n, pc); end
    run_req = 0; bp_en = 0; tick();
  endtask

  task automatic test_halt_boundary();
    logic r0, d0, r1, d1;
    mc = 1; run_req = 1; clr_cnt = 1; tick(); clr_cnt = 0;
    halt_req = 1;
    tick(); r0 = obs_run; d0 = obs_done;
    tick(); r1 = obs_run; d1 = obs_done;
    halt_req = 0; run_req = 0; mc = 0;
    total++; if ({r0, d0, r1, d1} !== 4'b1011) begin bad++; $display("FAIL halt_mc run/done=%b%b%b%b exp=1011", r0, d0, r1, d1); end
    total++; if (a.state !== ST_HALT || a.instr_count !== 16'd1) begin bad++; $display("FAIL halt_mc_end st=%0d ins=%0d exp=0/1", a.state, a.instr_count); end
  endtask

  task automatic test_saturation();
    mc = 0; bp_en = 0; run_req = 1; clr_cnt = 1; tick(); clr_cnt = 0;
    repeat (20) tick();
    total++; if (b.cycle_count !== 4'd15 || b.instr_count !== 4'd15) begin bad++; $display("FAIL sat_hold cyc=%0d ins=%0d exp=15/15", b.cycle_count, b.instr_count); end
    total++; if (a.cycle_count !== 16'd20) begin bad++; $display("FAIL sat_wide cyc=%0d exp=20", a.cycle_count); end
    clr_cnt = 1; tick(); clr_cnt = 0;
    total++; if (b.cycle_count !== 4'd0 || a.cycle_count !== 16'd0 || a.instr_count !== 16'd0) begin bad++; $display("FAIL sat_clr c4=%0d c=%0d i=%0d exp=0", b.cycle_count, a.cycle_count, a.instr_count); end
  endtask

  task automatic test_async_reset();
    tick();
    total++; if (a.cpu_run !== 1'b1) begin bad++; $display("FAIL ares_pre run=%b exp=1", a.cpu_run); end
    reset = 0; #1;
    total++; if (a.cpu_run !== 1'b0 || a.halted !== 1'b1 || a.cycle_count !== 16'd0) begin bad++; $display("FAIL ares_drop run=%b halted=%b cyc=%0d exp=0/1/0", a.cpu_run, a.halted, a.cycle_count); end
    model_reset(); run_req = 0;
    @(posedge clock); #1 reset = 1;
  endtask

  task automatic test_random();
    bp_addr = PC_W'($urandom_range(0, 7));
    for (int i = 0; i < 400; i++) begin
      run_req = $urandom_range(0, 3) != 0; halt_req = $urandom_range(0, 7) == 0;
      step_req = $urandom_range(0, 3) == 0; mc = $urandom_range(0, 2) == 0;
      pc = PC_W'($urandom_range(0, 7)); bp_en = $urandom_range(0, 1) == 1;
      clr_cnt = $urandom_range(0, 31) == 0;
      tick();
      total++; if (obs_run !== m_run || obs_done !== m_done) begin bad++; $display("FAIL rnd_comb i=%0d run=%b done=%b exp=%b/%b", i, obs_run, obs_done, m_run, m_done); end
      total++; if (a.state !== 2'(m_mode) || a.halted !== (m_mode == 0 || m_mode == 3) || a.bp_flag !== (m_mode == 3)) begin bad++; $display("FAIL rnd_state i=%0d st=%0d exp=%0d", i, a.state, m_mode); end
      total++; if (a.cycle_count !== 16'(m_cyc) || a.instr_count !== 16'(m_ins)) begin bad++; $display("FAIL rnd_cnt i=%0d cyc=%0d ins=%0d exp=%0d/%0d", i, a.cycle_count, a.instr_count, m_cyc, m_ins); end
      total++; if (b.cycle_count !== 4'(m_cyc4) || b.instr_count !== 4'(m_ins4)) begin bad++; $display("FAIL rnd_cnt4 i=%0d cyc=%0d ins=%0d exp=%0d/%0d", i, b.cycle_count, b.instr_count, m_cyc4, m_ins4); end
    end
  endtask

  initial begin
    test_reset();
    test_step_single();
    test_step_multi();
    test_breakpoint();
    test_halt_boundary();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
